// File: rtl/mux_nto1_seq.sv
// Registered N-to-1 mux: manual select or round-robin scan over a channel mask; 1-cycle latency.
// Backpressure: a presented sample (and the scan pointer) holds while y_vld && !y_rdy.
module mux_nto1_seq #(
    parameter int N     = 8,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             blank,
    input  logic             mode,
    input  logic [SEL_W-1:0] s,
    input  logic [N-1:0]     mask,
    input  logic [N*W-1:0]   i,
    output logic [W-1:0]     y,
    output logic [SEL_W-1:0] y_ch,
    output logic             y_err,
    output logic             y_vld,
    input  logic             y_rdy
);

    localparam logic [SEL_W:0] NUM_CH = (SEL_W+1)'(N);

    logic [W-1:0]     y_q, y_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic             err_q, err_d;
    logic             vld_q, vld_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             cap;
    logic             s_ok;
    logic [W-1:0]     s_dat;
    logic             scan_hit;
    logic [SEL_W-1:0] scan_c;
    logic [W-1:0]     scan_dat;

    assign cap  = !vld_q || y_rdy;
    assign s_ok = {1'b0, s} < NUM_CH;

    always_comb begin
        s_dat = '0;
        for (int k = 0; k < N; k++) begin
            if (s == SEL_W'(k)) begin
                s_dat = i[k*W +: W];
            end
        end
    end

    // First enabled channel found cyclically starting at ptr_q.
    always_comb begin
        int idx;
        idx      = 0;
        scan_hit = 1'b0;
        scan_c   = '0;
        scan_dat = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!scan_hit && mask[idx]) begin
                scan_hit = 1'b1;
                scan_c   = SEL_W'(idx);
                scan_dat = i[idx*W +: W];
            end
        end
    end

    always_comb begin
        y_d   = y_q;
        ch_d  = ch_q;
        err_d = err_q;
        vld_d = vld_q;
        ptr_d = ptr_q;
        if (cap) begin
            if (!mode) begin
                ch_d  = s;
                vld_d = 1'b1;
                ptr_d = '0;
                if (s_ok) begin
                    y_d   = blank ? '0 : s_dat;
                    err_d = 1'b0;
                end else begin
                    y_d   = '0;
                    err_d = 1'b1;
                end
            end else if (scan_hit) begin
                y_d   = blank ? '0 : scan_dat;
                ch_d  = scan_c;
                err_d = 1'b0;
                vld_d = 1'b1;
                ptr_d = (scan_c == SEL_W'(N-1)) ? '0 : scan_c + 1'b1;
            end else begin
                // Nothing enabled: drop valid, keep the pointer where it is.
                vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            ch_q  <= '0;
            err_q <= 1'b0;
            vld_q <= 1'b0;
            ptr_q <= '0;
        end else begin
            y_q   <= y_d;
            ch_q  <= ch_d;
            err_q <= err_d;
            vld_q <= vld_d;
            ptr_q <= ptr_d;
        end
    end

    assign y     = y_q;
    assign y_ch  = ch_q;
    assign y_err = err_q;
    assign y_vld = vld_q;

endmodule

// File: tb/tb_mux_nto1_seq.sv
// Bench for mux_nto1_seq: an N=8 and an N=6 instance driven side by side against a sample-level model.
module tb_mux_nto1_seq;

    logic clk;
    logic rst_n;

    logic        blank8, mode8, rdy8;
    logic [2:0]  s8;
    logic [7:0]  mask8;
    logic [63:0] i8;
    logic [7:0]  y8;
    logic [2:0]  ch8;
    logic        err8, vld8;

    logic        blank6, mode6, rdy6;
    logic [2:0]  s6;
    logic [5:0]  mask6;
    logic [47:0] i6;
    logic [7:0]  y6;
    logic [2:0]  ch6;
    logic        err6, vld6;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] y;
        logic [2:0] ch;
        logic       err;
        logic       vld;
        int         ptr;
    } mstate_t;

    mstate_t m8, m6, mrst;

    mux_nto1_seq #(.N(8), .W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .blank(blank8), .mode(mode8), .s(s8),
        .mask(mask8), .i(i8), .y(y8), .y_ch(ch8), .y_err(err8),
        .y_vld(vld8), .y_rdy(rdy8)
    );

    mux_nto1_seq #(.N(6), .W(8)) dut6 (
        .clk(clk), .rst_n(rst_n), .blank(blank6), .mode(mode6), .s(s6),
        .mask(mask6), .i(i6), .y(y6), .y_ch(ch6), .y_err(err6),
        .y_vld(vld6), .y_rdy(rdy6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One output sample per call: what the channel set presents after one edge.
    function automatic mstate_t mnext(mstate_t m, int n, logic blk, logic md, int sel,
                                      logic [7:0] msk, logic [63:0] dat, logic rdy);
        mstate_t r;
        int c;
        r = m;
        c = -1;
        if (m.vld && !rdy) return r;
        if (!md) begin
            r.ch  = 3'(sel);
            r.vld = 1'b1;
            r.ptr = 0;
            if (sel < n) begin
                r.y   = blk ? 8'h00 : dat[sel*8 +: 8];
                r.err = 1'b0;
            end else begin
                r.y   = 8'h00;
                r.err = 1'b1;
            end
        end else begin
            for (int k = 0; k < n; k++) begin
                if (c < 0 && msk[(m.ptr + k) % n]) c = (m.ptr + k) % n;
            end
            if (c < 0) begin
                r.vld = 1'b0;
            end else begin
                r.y   = blk ? 8'h00 : dat[c*8 +: 8];
                r.ch  = 3'(c);
                r.err = 1'b0;
                r.vld = 1'b1;
                r.ptr = (c + 1) % n;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all();
        chk("d8_y",   32'(y8),   32'(m8.y));
        chk("d8_ch",  32'(ch8),  32'(m8.ch));
        chk("d8_err", 32'(err8), 32'(m8.err));
        chk("d8_vld", 32'(vld8), 32'(m8.vld));
        chk("d6_y",   32'(y6),   32'(m6.y));
        chk("d6_ch",  32'(ch6),  32'(m6.ch));
        chk("d6_err", 32'(err6), 32'(m6.err));
        chk("d6_vld", 32'(vld6), 32'(m6.vld));
    endtask

    // Inputs are stable here (driven at the falling edge); sample 1 time unit after the rising edge.
    task automatic tick();
        m8 = mnext(m8, 8, blank8, mode8, int'(s8), mask8, i8, rdy8);
        m6 = mnext(m6, 6, blank6, mode6, int'(s6), {2'b00, mask6}, {16'h0, i6}, rdy6);
        @(posedge clk);
        #1;
        cmp_all();
        @(negedge clk);
    endtask

    initial begin
        int scan_seq[6] = '{0, 2, 5, 7, 0, 2};
        int budget;

        mrst = '{y: 8'h00, ch: 3'd0, err: 1'b0, vld: 1'b0, ptr: 0};
        m8 = mrst;
        m6 = mrst;

        rst_n  = 1'b0;
        blank8 = 1'b0; mode8 = 1'b0; s8 = 3'd0; mask8 = 8'h00; rdy8 = 1'b1;
        blank6 = 1'b0; mode6 = 1'b0; s6 = 3'd0; mask6 = 6'h00; rdy6 = 1'b1;
        for (int k = 0; k < 8; k++) i8[k*8 +: 8] = 8'(8'h10 + k);
        for (int k = 0; k < 6; k++) i6[k*8 +: 8] = 8'(8'h20 + k);

        // Reset state
        #12;
        chk("rst_y",   32'(y8),   32'h0);
        chk("rst_ch",  32'(ch8),  32'h0);
        chk("rst_err", 32'(err8), 32'h0);
        chk("rst_vld", 32'(vld8), 32'h0);
        chk("rst_vld6", 32'(vld6), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Manual sweep
        for (int k = 0; k < 8; k++) begin
            s8 = 3'(k);
            tick();
            chk("sweep_y",  32'(y8),  32'(8'h10 + k));
            chk("sweep_ch", 32'(ch8), 32'(k));
        end

        // Back-pressure: hold channel 3 for 4 cycles while s and data move
        s8 = 3'd3;
        tick();
        rdy8 = 1'b0;
        s8 = 3'd5;
        for (int n = 0; n < 4; n++) begin
            i8 = {$urandom, $urandom};
            tick();
            chk("stall_y",  32'(y8),  32'h13);
            chk("stall_ch", 32'(ch8), 32'd3);
        end
        for (int k = 0; k < 8; k++) i8[k*8 +: 8] = 8'(8'h10 + k);
        rdy8 = 1'b1;
        tick();
        chk("release_y",  32'(y8),  32'h15);
        chk("release_ch", 32'(ch8), 32'd5);

        // Scan over a sparse mask, then an empty mask, then resume
        mode8 = 1'b1;
        mask8 = 8'b1010_0101;
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("scan_ch", 32'(ch8), 32'(scan_seq[n]));
        end
        mask8 = 8'h00;
        tick();
        chk("scan_empty_vld", 32'(vld8), 32'h0);
        mask8 = 8'b1010_0101;
        tick();
        chk("scan_resume_ch", 32'(ch8), 32'd5);

        // N=6: blanked sample, then out-of-range select
        blank6 = 1'b1; s6 = 3'd2;
        tick();
        chk("blank_y",   32'(y6),   32'h0);
        chk("blank_ch",  32'(ch6),  32'd2);
        chk("blank_vld", 32'(vld6), 32'h1);
        chk("blank_err", 32'(err6), 32'h0);
        blank6 = 1'b0; s6 = 3'd7;
        tick();
        chk("oor_y",   32'(y6),   32'h0);
        chk("oor_err", 32'(err6), 32'h1);
        chk("oor_ch",  32'(ch6),  32'd7);

        // Mode switch restarts the scan at channel 0
        mask8 = 8'hFF;
        budget = 0;
        while (!(vld8 && ch8 == 3'd4) && budget < 16) begin
            tick();
            budget++;
        end
        chk("reach_ch4", 32'(ch8), 32'd4);
        mode8 = 1'b0; s8 = 3'd6;
        tick();
        mode8 = 1'b1;
        tick();
        chk("modesw_ch", 32'(ch8), 32'd0);

        // Randomized traffic on both instances
        for (int n = 0; n < 400; n++) begin
            blank8 = 1'($urandom_range(0, 3) == 0);
            mode8  = 1'($urandom_range(0, 3) != 0);
            s8     = 3'($urandom);
            mask8  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            i8     = {$urandom, $urandom};
            rdy8   = 1'($urandom_range(0, 3) != 0);
            blank6 = 1'($urandom_range(0, 3) == 0);
            mode6  = 1'($urandom_range(0, 2) != 0);
            s6     = 3'($urandom);
            mask6  = ($urandom_range(0, 7) == 0) ? 6'h00 : 6'($urandom);
            i6     = {16'($urandom), $urandom};
            rdy6   = 1'($urandom_range(0, 3) != 0);
            tick();
        end

        // Async reset during a stall
        blank8 = 1'b0; mode8 = 1'b0; s8 = 3'd6; rdy8 = 1'b1;
        for (int k = 0; k < 8; k++) i8[k*8 +: 8] = 8'(8'h10 + k);
        tick();
        rdy8 = 1'b0;
        tick();
        chk("stall_pre_vld", 32'(vld8), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_y",   32'(y8),   32'h0);
        chk("arst_ch",  32'(ch8),  32'h0);
        chk("arst_vld", 32'(vld8), 32'h0);
        m8 = mrst;
        m6 = mrst;
        mode8 = 1'b1; mask8 = 8'hFF; rdy8 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ch",  32'(ch8),  32'd0);
        chk("post_rst_vld", 32'(vld8), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
